// File: rtl/fpdiv_pkg.sv
// fpdiv_pkg: shared types and constants for the fpdiv Goldschmidt sequencer.
//   fpdiv_state_t  - sequencer FSM states
//   SEL3_* / SEL4_* - datapath multiplier mux select encodings
//   fpdiv_result_t - quotient + rounding op_type pair
//   DEFAULT_ITERS  - default Goldschmidt iteration count
package fpdiv_pkg;

    localparam int DEFAULT_ITERS = 3;

    typedef enum logic [2:0] {
        IDLE,
        N0,
        D0,
        NI,
        DI,
        REM,
        CAPT,
        OUT
    } fpdiv_state_t;

    // mux3 feeds one multiplier operand: seed approximation, regc or the denominator.
    localparam logic [1:0] SEL3_IA    = 2'd0;
    localparam logic [1:0] SEL3_REGC  = 2'd1;
    localparam logic [1:0] SEL3_DENOM = 2'd2;

    // mux4 feeds the other multiplier operand.
    localparam logic [1:0] SEL4_NUM   = 2'd0;
    localparam logic [1:0] SEL4_DENOM = 2'd1;
    localparam logic [1:0] SEL4_REGA  = 2'd2;
    localparam logic [1:0] SEL4_REGB  = 2'd3;

    typedef struct packed {
        logic [31:0] ans;
        logic [1:0]  op_type;
    } fpdiv_result_t;

endpackage

// File: rtl/fpdiv_special_chk.sv
// fpdiv_special_chk: combinational zero-exponent classifier for an operand pair.
//   num, denom  in  IEEE-754 single operands
//   is_special  out pair bypasses the Goldschmidt datapath
//   result      out bypass quotient: denom exp 0 -> signed infinity,
//                   else num exp 0 -> signed zero; op_type always 0
// Only instantiated when FPDIV_SEQ_SPECIAL_EN is defined.
module fpdiv_special_chk
    import fpdiv_pkg::*;
(
    input  logic [31:0]   num,
    input  logic [31:0]   denom,
    output logic          is_special,
    output fpdiv_result_t result
);

    logic sign;
    logic num_zexp;
    logic denom_zexp;

    assign sign       = num[31] ^ denom[31];
    assign num_zexp   = (num[30:23] == 8'h00);
    assign denom_zexp = (denom[30:23] == 8'h00);

    assign is_special     = num_zexp | denom_zexp;
    // Denominator check wins: 0/0 reports infinity.
    assign result.ans     = denom_zexp ? {sign, 8'hFF, 23'h0} : {sign, 31'h0};
    assign result.op_type = 2'd0;

endmodule

// File: rtl/fpdiv_seq.sv
// fpdiv_seq: control/handshake sequencer in front of the fpdiv Goldschmidt datapath.
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_num, in_denom, in_rm   operand handshake
//   dp_num, dp_denom, dp_rm                      latched operands to datapath
//   dp_en_a, dp_en_b, dp_en_rem                  datapath register enables
//   dp_sel_mux3, dp_sel_mux4                     multiplier operand selects
//   dp_final_ans, dp_op_type                     datapath result (combinational)
//   out_valid/out_ready, out_ans, out_op_type    registered result handshake
// Parameter ITERS (>=1): number of N/D Goldschmidt multiply pairs.
// Optional macro FPDIV_SEQ_SPECIAL_EN: zero-exponent operands bypass the
// datapath and present a signed zero/infinity one cycle after accept.
module fpdiv_seq
    import fpdiv_pkg::*;
#(
    parameter int ITERS = DEFAULT_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num,
    input  logic [31:0] in_denom,
    input  logic        in_rm,
    output logic [31:0] dp_num,
    output logic [31:0] dp_denom,
    output logic        dp_rm,
    output logic        dp_en_a,
    output logic        dp_en_b,
    output logic        dp_en_rem,
    output logic [1:0]  dp_sel_mux3,
    output logic [1:0]  dp_sel_mux4,
    input  logic [31:0] dp_final_ans,
    input  logic [1:0]  dp_op_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ans,
    output logic [1:0]  out_op_type
);

    localparam int              CNT_W     = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] ITERS_CNT = CNT_W'(ITERS);

    fpdiv_state_t     state;
    fpdiv_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             special;
    fpdiv_result_t    special_res;

    assign accept  = (state == IDLE) && in_valid;
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef FPDIV_SEQ_SPECIAL_EN
    fpdiv_special_chk u_special_chk (
        .num        (in_num),
        .denom      (in_denom),
        .is_special (special),
        .result     (special_res)
    );
`else
    assign special     = 1'b0;
    assign special_res = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments so every register in the design samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = special ? OUT : N0;
            N0:   state_nxt = D0;
            D0:   state_nxt = (ITERS == 1) ? REM : NI;
            NI:   state_nxt = DI;
            // cnt holds the count of finished pairs; this DI finishes one more.
            DI:   state_nxt = (cnt_inc == ITERS_CNT) ? REM : NI;
            REM:  state_nxt = CAPT;
            CAPT: state_nxt = OUT;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: enables/selects are a pure function of state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        dp_en_a     = 1'b0;
        dp_en_b     = 1'b0;
        dp_en_rem   = 1'b0;
        dp_sel_mux3 = SEL3_IA;
        dp_sel_mux4 = SEL4_NUM;
        case (state)
            IDLE: in_ready = 1'b1;
            N0: begin
                dp_sel_mux3 = SEL3_IA;
                dp_sel_mux4 = SEL4_NUM;
                dp_en_a     = 1'b1;
            end
            D0: begin
                dp_sel_mux3 = SEL3_IA;
                dp_sel_mux4 = SEL4_DENOM;
                dp_en_b     = 1'b1;
            end
            NI: begin
                dp_sel_mux3 = SEL3_REGC;
                dp_sel_mux4 = SEL4_REGA;
                dp_en_a     = 1'b1;
            end
            DI: begin
                dp_sel_mux3 = SEL3_REGC;
                dp_sel_mux4 = SEL4_REGB;
                dp_en_b     = 1'b1;
            end
            REM: begin
                dp_sel_mux3 = SEL3_DENOM;
                dp_sel_mux4 = SEL4_REGA;
                dp_en_rem   = 1'b1;
            end
            // Selects stay on the remainder path while final_ans settles.
            CAPT: begin
                dp_sel_mux3 = SEL3_DENOM;
                dp_sel_mux4 = SEL4_REGA;
            end
            OUT: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Iteration counter: 1 after D0, +1 per DI, so it never exceeds ITERS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE:    cnt <= '0;
                D0:      cnt <= CNT_W'(1);
                DI:      cnt <= cnt_inc;
                default: ;
            endcase
        end
    end

    // Operand and result registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: data registers are reset too, so a reset mid-operation leaves no stale result visible.
        if (!reset) begin
            dp_num      <= '0;
            dp_denom    <= '0;
            dp_rm       <= 1'b0;
            out_ans     <= '0;
            out_op_type <= '0;
        end else begin
            if (accept) begin
                dp_num   <= in_num;
                dp_denom <= in_denom;
                dp_rm    <= in_rm;
            end
            if (state == CAPT) begin
                out_ans     <= dp_final_ans;
                out_op_type <= dp_op_type;
            end else if (accept && special) begin
                out_ans     <= special_res.ans;
                out_op_type <= special_res.op_type;
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_seq.sv
// tb_fpdiv_seq: self-checking bench for fpdiv_seq.
// The bench plays the datapath: dp_final_ans/dp_op_type carry fresh random
// values every cycle except the capture cycle, where the intended result is
// presented. Expected control traces are built from the step list
// N0, D0, (NI, DI) x (ITERS-1), REM, CAPT, then OUT.
module tb_fpdiv_seq;

    localparam int ITERS = 3;

    // {in_ready, out_valid, en_a, en_b, en_rem, sel3[1:0], sel4[1:0]}
    localparam logic [8:0] C_IDLE = 9'b1_0_000_00_00;
    localparam logic [8:0] C_N0   = 9'b0_0_100_00_00;
    localparam logic [8:0] C_D0   = 9'b0_0_010_00_01;
    localparam logic [8:0] C_NI   = 9'b0_0_100_01_10;
    localparam logic [8:0] C_DI   = 9'b0_0_010_01_11;
    localparam logic [8:0] C_REM  = 9'b0_0_001_10_10;
    localparam logic [8:0] C_CAPT = 9'b0_0_000_10_10;
    localparam logic [8:0] C_OUT  = 9'b0_1_000_00_00;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_num;
    logic [31:0] in_denom;
    logic        in_rm;
    logic [31:0] dp_num;
    logic [31:0] dp_denom;
    logic        dp_rm;
    logic        dp_en_a;
    logic        dp_en_b;
    logic        dp_en_rem;
    logic [1:0]  dp_sel_mux3;
    logic [1:0]  dp_sel_mux4;
    logic [31:0] dp_final_ans;
    logic [1:0]  dp_op_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ans;
    logic [1:0]  out_op_type;

    int n_checks = 0;
    int n_errors = 0;

    fpdiv_seq #(.ITERS(ITERS)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_num       (in_num),
        .in_denom     (in_denom),
        .in_rm        (in_rm),
        .dp_num       (dp_num),
        .dp_denom     (dp_denom),
        .dp_rm        (dp_rm),
        .dp_en_a      (dp_en_a),
        .dp_en_b      (dp_en_b),
        .dp_en_rem    (dp_en_rem),
        .dp_sel_mux3  (dp_sel_mux3),
        .dp_sel_mux4  (dp_sel_mux4),
        .dp_final_ans (dp_final_ans),
        .dp_op_type   (dp_op_type),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ans      (out_ans),
        .out_op_type  (out_op_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] num;
        logic [31:0] denom;
        logic        rm;
        logic [31:0] ans;      // value the fake datapath shows in the capture cycle
        logic [1:0]  op;
        int          hold;     // cycles out_ready stays low in OUT
        bit          hold_iv;  // keep in_valid high with altered operands while busy
        bit          noise;    // toggle out_ready randomly while busy
    } vec_t;

    logic [8:0] exp_steps[$];

    function automatic logic [8:0] ctrl();
        return {in_ready, out_valid, dp_en_a, dp_en_b, dp_en_rem, dp_sel_mux3, dp_sel_mux4};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: is the pair a bypass case, and what result does it produce.
    task automatic model(input vec_t v, output bit spec, output logic [31:0] ans, output logic [1:0] op);
        logic sign;
        sign = v.num[31] ^ v.denom[31];
        spec = 1'b0;
        ans  = v.ans;
        op   = v.op;
`ifdef FPDIV_SEQ_SPECIAL_EN
        if (v.denom[30:23] == 8'h00) begin
            spec = 1'b1; ans = {sign, 8'hFF, 23'h0}; op = 2'd0;
        end else if (v.num[30:23] == 8'h00) begin
            spec = 1'b1; ans = {sign, 31'h0}; op = 2'd0;
        end
`endif
    endtask

    task automatic build_steps(input bit spec);
        exp_steps.delete();
        if (!spec) begin
            exp_steps.push_back(C_N0);
            exp_steps.push_back(C_D0);
            for (int i = 1; i < ITERS; i++) begin
                exp_steps.push_back(C_NI);
                exp_steps.push_back(C_DI);
            end
            exp_steps.push_back(C_REM);
            exp_steps.push_back(C_CAPT);
        end
    endtask

    // One full transaction; called and returns at a negedge with the DUT in IDLE.
    task automatic run_txn(input vec_t v);
        bit          spec;
        logic [31:0] exp_ans;
        logic [1:0]  exp_op;
        model(v, spec, exp_ans, exp_op);
        build_steps(spec);

        check("idle_before_accept", ctrl(), C_IDLE);
        in_valid     = 1'b1;
        in_num       = v.num;
        in_denom     = v.denom;
        in_rm        = v.rm;
        dp_final_ans = $urandom;
        dp_op_type   = 2'($urandom);
        @(posedge clk); @(negedge clk);

        foreach (exp_steps[j]) begin
            check("busy_ctrl", ctrl(), exp_steps[j]);
            check("busy_dp_ops", {dp_rm, dp_denom, dp_num}, {v.rm, v.denom, v.num});
            if (v.hold_iv) begin
                in_num   = ~v.num;
                in_denom = v.denom ^ 32'h0055_AA00;
                in_rm    = ~v.rm;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = v.noise ? 1'($urandom) : 1'b0;
            if (exp_steps[j] == C_CAPT) begin
                dp_final_ans = v.ans;
                dp_op_type   = v.op;
            end else begin
                dp_final_ans = $urandom;
                dp_op_type   = 2'($urandom);
            end
            @(posedge clk); @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int h = 0; h <= v.hold; h++) begin
            check("out_ctrl", ctrl(), C_OUT);
            check("out_ans", out_ans, exp_ans);
            check("out_op_type", out_op_type, exp_op);
            dp_final_ans = $urandom;
            dp_op_type   = 2'($urandom);
            if (h == v.hold) out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        out_ready = 1'b0;
        check("consumed_ctrl", ctrl(), C_IDLE);
        check("dp_ops_held", {dp_rm, dp_denom, dp_num}, {v.rm, v.denom, v.num});
    endtask

    vec_t table_v[5];

    initial begin
        // Timeout guard: the flow below is fixed-length, this only catches a stuck simulator.
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset        = 1'b0;
        in_valid     = 1'b0;
        in_num       = '0;
        in_denom     = '0;
        in_rm        = 1'b0;
        dp_final_ans = '0;
        dp_op_type   = '0;
        out_ready    = 1'b0;

        table_v[0] = '{32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 2'd0, 5, 1'b0, 1'b0};
        table_v[1] = '{32'h3F80_0000, 32'h4040_0000, 1'b0, 32'h3EAA_AAAA, 2'd2, 0, 1'b1, 1'b0};
        table_v[2] = '{32'hC120_0000, 32'h4080_0000, 1'b1, 32'hC020_0000, 2'd1, 2, 1'b0, 1'b1};
        table_v[3] = '{32'h3F80_0000, 32'h8000_0000, 1'b1, 32'h1234_5678, 2'd3, 1, 1'b0, 1'b0};
        table_v[4] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'hDEAD_BEEF, 2'd2, 0, 1'b1, 1'b1};

        // Reset state while reset is held.
        #12;
        check("reset_ctrl", ctrl(), C_IDLE);
        check("reset_dp_ops", {dp_rm, dp_denom, dp_num}, 65'd0);
        check("reset_out", {out_op_type, out_ans}, 34'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_ctrl", ctrl(), C_IDLE);

        // in_valid low and stray out_ready in IDLE do nothing.
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_ignored", ctrl(), C_IDLE);

        foreach (table_v[i]) run_txn(table_v[i]);

        // Reset in the middle of an operation: abort, clear everything.
        in_valid = 1'b1;
        in_num   = 32'h4100_0000;
        in_denom = 32'h4000_0000;
        in_rm    = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        build_steps(1'b0);
        repeat (3) begin @(posedge clk); end
        @(negedge clk);
        check("pre_abort_ctrl", ctrl(), exp_steps[3]);
        #1 reset = 1'b0;
        #1;
        check("abort_ctrl", ctrl(), C_IDLE);
        check("abort_dp_ops", {dp_rm, dp_denom, dp_num}, 65'd0);
        check("abort_out", {out_valid, out_op_type, out_ans}, 35'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_release_ctrl", ctrl(), C_IDLE);

        // Randomized transactions.
        for (int k = 0; k < 20; k++) begin
            v.num   = $urandom;
            v.denom = $urandom;
            if ($urandom_range(0, 3) == 0) v.denom[30:23] = 8'h00;
            if ($urandom_range(0, 3) == 0) v.num[30:23]   = 8'h00;
            v.rm      = 1'($urandom);
            v.ans     = $urandom;
            v.op      = 2'($urandom);
            v.hold    = $urandom_range(0, 3);
            v.hold_iv = 1'($urandom);
            v.noise   = 1'($urandom);
            run_txn(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
